// File: rtl/ir_beacon_detect_pkg.sv
// rtl/ir_beacon_detect_pkg.sv - channel state encoding and default window/band constants for ir_beacon_detect
package ir_beacon_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2,
        HOLD = 2'd3
    } chanState_t;

    localparam int DEF_GATE_CYCLES = 10000000;
    localparam int DEF_F_MIN_CNT   = 90;
    localparam int DEF_F_MAX_CNT   = 110;
    localparam int DEF_CONFIRM     = 2;
    localparam int DEF_RELEASE     = 3;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/ir_chan_detect.sv
// rtl/ir_chan_detect.sv - one IR channel: sync, optional majority filter (IR_GLITCH_FILTER_EN), edge count, found FSM
module ir_chan_detect
    import ir_beacon_detect_pkg::*;
#(
    parameter int F_MIN_CNT = DEF_F_MIN_CNT,
    parameter int F_MAX_CNT = DEF_F_MAX_CNT,
    parameter int CONFIRM   = DEF_CONFIRM,
    parameter int RELEASE   = DEF_RELEASE,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic irRaw,
    input  logic gateTick,
    output logic found
);

    localparam int HIT_W  = $clog2(CONFIRM + 1);
    localparam int MISS_W = $clog2(RELEASE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sync1;
    logic sync2;
    logic lvl;
    logic prevLvl;
    logic risingEdge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= irRaw;
            sync2 <= sync1;
        end
    end

`ifdef IR_GLITCH_FILTER_EN
    logic dly1;
    logic dly2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly1 <= 1'b0;
            dly2 <= 1'b0;
        end else begin
            dly1 <= sync2;
            dly2 <= dly1;
        end
    end

    // 2-of-3 vote: a level must persist two samples before it is believed
    assign lvl = (sync2 & dly1) | (sync2 & dly2) | (dly1 & dly2);
`else
    assign lvl = sync2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prevLvl <= 1'b0;
        end else begin
            prevLvl <= lvl;
        end
    end

    assign risingEdge = lvl & ~prevLvl;

    logic [CNT_W-1:0] edgeCnt;
    logic [CNT_W-1:0] winCnt;
    logic             inBand;

    // winCnt includes an edge landing on the tick cycle itself
    always_comb begin
        winCnt = edgeCnt;
        if (risingEdge && (edgeCnt != CNT_MAX)) begin
            winCnt = edgeCnt + 1'b1;
        end
    end

    assign inBand = (winCnt >= CNT_W'(F_MIN_CNT)) && (winCnt <= CNT_W'(F_MAX_CNT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edgeCnt <= '0;
        end else if (gateTick) begin
            edgeCnt <= '0;
        end else begin
            edgeCnt <= winCnt;
        end
    end

    chanState_t        state;
    logic [HIT_W-1:0]  hits;
    logic [MISS_W-1:0] misses;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            hits   <= '0;
            misses <= '0;
            found  <= 1'b0;
        end else if (gateTick) begin
            case (state)
                IDLE: begin
                    if (inBand) begin
                        if (CONFIRM == 1) begin
                            state <= LOCK;
                            found <= 1'b1;
                        end else begin
                            state <= ACQ;
                            hits  <= HIT_W'(1);
                        end
                    end
                end
                ACQ: begin
                    if (!inBand) begin
                        state <= IDLE;
                        hits  <= '0;
                    end else if (hits + 1'b1 == HIT_W'(CONFIRM)) begin
                        state <= LOCK;
                        hits  <= '0;
                        found <= 1'b1;
                    end else begin
                        hits <= hits + 1'b1;
                    end
                end
                LOCK: begin
                    if (!inBand) begin
                        if (RELEASE == 1) begin
                            state <= IDLE;
                            found <= 1'b0;
                        end else begin
                            state  <= HOLD;
                            misses <= MISS_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (inBand) begin
                        state  <= LOCK;
                        misses <= '0;
                    end else if (misses + 1'b1 == MISS_W'(RELEASE)) begin
                        state  <= IDLE;
                        misses <= '0;
                        found  <= 1'b0;
                    end else begin
                        misses <= misses + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    hits   <= '0;
                    misses <= '0;
                    found  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ir_beacon_detect.sv
// rtl/ir_beacon_detect.sv - two-channel IR beacon detector with shared gate window; IR_GLITCH_FILTER_EN adds input majority filter
module ir_beacon_detect
    import ir_beacon_detect_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int F_MIN_CNT   = DEF_F_MIN_CNT,
    parameter int F_MAX_CNT   = DEF_F_MAX_CNT,
    parameter int CONFIRM     = DEF_CONFIRM,
    parameter int RELEASE     = DEF_RELEASE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ir_raw,
    output logic [1:0] ir_found,
    output logic       gate_tick
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_PRE  = GATE_W'(GATE_CYCLES - 2);

    logic [GATE_W-1:0] gateCnt;

    // tick is registered one count early so it is high exactly while gateCnt == GATE_LAST
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gateCnt   <= '0;
            gate_tick <= 1'b0;
        end else begin
            gateCnt   <= (gateCnt == GATE_LAST) ? '0 : gateCnt + 1'b1;
            gate_tick <= (gateCnt == GATE_PRE);
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : gChan
        ir_chan_detect #(
            .F_MIN_CNT (F_MIN_CNT),
            .F_MAX_CNT (F_MAX_CNT),
            .CONFIRM   (CONFIRM),
            .RELEASE   (RELEASE),
            .CNT_W     (CNT_W)
        ) uChan (
            .clk      (clk),
            .reset    (reset),
            .irRaw    (ir_raw[ch]),
            .gateTick (gate_tick),
            .found    (ir_found[ch])
        );
    end

endmodule

// File: tb/tb_ir_beacon_detect.sv
// tb/tb_ir_beacon_detect.sv - directed table-driven bench for ir_beacon_detect
module tb_ir_beacon_detect;
    import ir_beacon_detect_pkg::*;

    localparam int GATE = 1000;
`ifdef IR_GLITCH_FILTER_EN
    localparam int FILT_LAT = 1;
    localparam logic [1:0] GLITCH_EXP = 2'b00;
`else
    localparam int FILT_LAT = 0;
    localparam logic [1:0] GLITCH_EXP = 2'b11;
`endif
    // raw rise here lands its counted edge on the tick cycle
    localparam int LATE_START = GATE - 2 - FILT_LAT;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ir_raw;
    logic [1:0] ir_found;
    logic       gate_tick;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] prevFound;

    ir_beacon_detect #(
        .GATE_CYCLES (GATE),
        .F_MIN_CNT   (9),
        .F_MAX_CNT   (11),
        .CONFIRM     (2),
        .RELEASE     (3),
        .CNT_W       (DEF_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ir_raw    (ir_raw),
        .ir_found  (ir_found),
        .gate_tick (gate_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n0;
        int         n1;
        logic [1:0] late;
        logic [1:0] expFound;
    } vec_t;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic pulseLvl(input int c, input int n, input logic late, input int w);
        int regN;
        regN = late ? n - 1 : n;
        if (late && c >= LATE_START && c < GATE) return 1'b1;
        if (c >= 10 && c < 10 + regN * 40 && ((c - 10) % 40) < w) return 1'b1;
        return 1'b0;
    endfunction

    task automatic waitTick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!gate_tick && cyc < 2 * GATE);
        if (!gate_tick) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout: no gate_tick within %0d cycles", cyc);
        end
    endtask

    // starts just after a tick cycle, drives one full window, checks tick and found timing
    task automatic doWindow(input int n0, input int n1, input logic [1:0] late, input int w,
                            input logic [1:0] exp, input string tag);
        for (int c = 1; c <= GATE; c++) begin
            @(negedge clk);
            ir_raw = {pulseLvl(c, n1, late[1], w), pulseLvl(c, n0, late[0], w)};
        end
        check({tag, " tick"}, {1'b0, gate_tick}, 2'b01);
        check({tag, " found_before_tick"}, ir_found, prevFound);
        @(posedge clk);
        #1;
        check({tag, " found"}, ir_found, exp);
        prevFound = exp;
    endtask

    initial begin
        vec_t vecs[24];
        int   cyc;

        vecs[0]  = '{10, 0, 2'b00, 2'b00};
        vecs[1]  = '{10, 0, 2'b00, 2'b01};
        vecs[2]  = '{20, 20, 2'b00, 2'b01};
        vecs[3]  = '{20, 20, 2'b00, 2'b01};
        vecs[4]  = '{20, 20, 2'b00, 2'b00};
        vecs[5]  = '{20, 20, 2'b00, 2'b00};
        vecs[6]  = '{9, 11, 2'b11, 2'b00};
        vecs[7]  = '{11, 9, 2'b10, 2'b11};
        vecs[8]  = '{8, 12, 2'b01, 2'b11};
        vecs[9]  = '{8, 12, 2'b00, 2'b11};
        vecs[10] = '{12, 8, 2'b11, 2'b00};
        vecs[11] = '{8, 12, 2'b10, 2'b00};
        vecs[12] = '{8, 12, 2'b00, 2'b00};
        vecs[13] = '{10, 10, 2'b00, 2'b00};
        vecs[14] = '{10, 10, 2'b00, 2'b11};
        vecs[15] = '{0, 10, 2'b00, 2'b11};
        vecs[16] = '{10, 10, 2'b00, 2'b11};
        vecs[17] = '{0, 0, 2'b00, 2'b11};
        vecs[18] = '{0, 0, 2'b00, 2'b11};
        vecs[19] = '{0, 0, 2'b00, 2'b00};
        vecs[20] = '{10, 0, 2'b00, 2'b00};
        vecs[21] = '{0, 0, 2'b00, 2'b00};
        vecs[22] = '{10, 0, 2'b00, 2'b00};
        vecs[23] = '{10, 0, 2'b00, 2'b01};

        reset = 1'b0;
        ir_raw = 2'b00;
        prevFound = 2'b00;
        repeat (3) @(negedge clk);
        check("reset found", ir_found, 2'b00);
        check("reset tick", {1'b0, gate_tick}, 2'b00);
        reset = 1'b1;

        waitTick(cyc);
        checks++;
        if (cyc != GATE - 1) begin
            failures++;
            $display("FAIL first_tick: got cycle %0d expected %0d", cyc, GATE - 1);
        end

        for (int i = 0; i < 24; i++) begin
            doWindow(vecs[i].n0, vecs[i].n1, vecs[i].late, 20, vecs[i].expFound,
                     $sformatf("vec%0d", i));
        end

        // async reset partway through a window while channel 0 is locked
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            ir_raw = {1'b0, pulseLvl(c, 10, 1'b0, 20)};
        end
        check("pre_reset found", ir_found, 2'b01);
        reset = 1'b0;
        ir_raw = 2'b00;
        #1;
        check("async reset found", ir_found, 2'b00);
        check("async reset tick", {1'b0, gate_tick}, 2'b00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        prevFound = 2'b00;
        waitTick(cyc);
        checks++;
        if (cyc != GATE - 1) begin
            failures++;
            $display("FAIL tick_after_reset: got cycle %0d expected %0d", cyc, GATE - 1);
        end
        doWindow(10, 10, 2'b00, 20, 2'b00, "relock1");
        doWindow(10, 10, 2'b00, 20, 2'b11, "relock2");

        // single-cycle pulses: rejected only when the majority filter is built in
        @(negedge clk);
        reset = 1'b0;
        ir_raw = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        prevFound = 2'b00;
        waitTick(cyc);
        doWindow(10, 10, 2'b00, 1, 2'b00, "glitch1");
        doWindow(10, 10, 2'b00, 1, GLITCH_EXP, "glitch2");
        doWindow(10, 10, 2'b00, 1, GLITCH_EXP, "glitch3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_beacon_detect.md
Name: ir_beacon_detect

Overview:
- Upstream stage of the line-follower motor controller; produces the 2-bit beacon-found vector that drives the controller's beaconfound transition.
- Takes two raw IR phototransistor square waves and synchronises each.
- Counts rising edges per channel over a fixed gate window and asserts a channel's found bit only after the edge count is in-band for CONFIRM consecutive windows.
- Deasserts a found bit only after RELEASE consecutive out-of-band windows (hysteresis).

Parameters:
- GATE_CYCLES, 10000000, clk cycles per gate window (100 ms at 100 MHz).
- F_MIN_CNT, 90, minimum in-band rising-edge count per window (inclusive).
- F_MAX_CNT, 110, maximum in-band rising-edge count per window (inclusive).
- CONFIRM, 2, consecutive in-band windows needed to assert found (≥1).
- RELEASE, 3, consecutive out-of-band windows needed to clear found (≥1).
- CNT_W, 16, edge counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- ir_raw  input  2  raw IR sensor levels; bit0 left, bit1 right; asynchronous to clk
- ir_found  output  2  per-channel beacon-present flag, registered; feeds the motor controller IR input
- gate_tick  output  1  one-cycle pulse on the last cycle of each gate window

Behaviour:
- Reset (reset=0, async): ir_found=0, gate_tick=0, gate counter=0, edge counters=0, synchronisers=0, all channel FSMs IDLE. On release, the first window starts at the first clk edge.
- Sync: 2-FF synchroniser per bit, then a previous-sample register. Rising edge = sync & ~prev.
- Gate counter runs 0..GATE_CYCLES-1 and wraps. gate_tick=1 when count==GATE_CYCLES-1 (registered compare, so the pulse is high during that cycle).
- Edge counter: increments on each edge and saturates, never wraps.
- On a gate_tick cycle:
  - window count = counter + edge_this_cycle (saturated).
  - counter is then loaded with 0, so the next window starts clean.
  - in_band = F_MIN_CNT ≤ window count ≤ F_MAX_CNT.
- Channel FSM evaluates only on gate_tick:
  - IDLE (found=0): in_band → ACQ with hits=1, or straight to LOCK if CONFIRM==1; else stay.
  - ACQ (found=0): in_band → hits+1; when hits reaches CONFIRM → LOCK. !in_band → IDLE, hits=0.
  - LOCK (found=1): !in_band → HOLD with misses=1, or straight to IDLE if RELEASE==1; else stay.
  - HOLD (found=1): in_band → LOCK, misses=0. !in_band → misses+1; when misses reaches RELEASE → IDLE.
- ir_found is registered from FSM state. It changes the cycle after the deciding gate_tick.
- Channels are fully independent. Both may change on the same tick.
- A constant-high or constant-low input gives count 0, which is out of band.

Optional Feature:
- IR_GLITCH_FILTER_EN defined: a 3-sample majority filter is inserted after the synchroniser, before edge detect. It adds 1 cycle of input latency, and single-cycle pulses or drops are rejected.
- Undefined: the synchroniser output feeds edge detect directly, so every synchronised rising edge counts.

Decomposition:
- Shared package: FSM state encoding (IDLE, ACQ, LOCK, HOLD), and default GATE_CYCLES, F_MIN_CNT, F_MAX_CNT constants reused by top-level and bench.
- Sub-module ir_chan_detect: one instance per channel. It holds the synchroniser, optional filter, edge counter, and FSM, and receives the shared gate_tick from the top.

Test Plan (GATE_CYCLES=1000, F_MIN_CNT=9, F_MAX_CNT=11, CONFIRM=2, RELEASE=3):
- ir_raw[0] square wave, period 100 cycles (10 edges/window) → ir_found[0]=1 one cycle after 2nd gate_tick; ir_found[1] stays 0.
- Period 50 cycles (20 edges/window) on both channels → ir_found stays 00 indefinitely.
- Boundary windows of exactly 8, 9, 11, 12 edges, including an edge on the gate_tick cycle → 9 and 11 in-band; 8 and 12 out.
- Locked channel, one window with 0 edges, then beacon resumes → ir_found stays 1. Beacon stopped → ir_found falls one cycle after 3rd empty-window tick.
- Assert reset mid-window while locked → ir_found=00 immediately (async). After release, 2 full windows are needed to relock.
- Macro defined, 1-cycle high pulses injected 10 per window → ir_found stays 0. Macro undefined, same stimulus → ir_found asserts after 2 windows.
